// File: rtl/l2_flush_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : l2_flush_sequencer_pkg
// Purpose : Shared L2 geometry constants, set/way index types and the flush
//           sequencer state encoding. The FSM and any debug/stats logic use
//           the same state encoding from this package.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package l2_flush_sequencer_pkg;

  localparam int L2_SETS     = 256;
  localparam int L2_WAYS     = 8;
  localparam int L2_SET_BITS = 8;
  localparam int L2_WAY_BITS = 3;

  typedef logic [L2_SET_BITS-1:0] l2_set_t;
  typedef logic [L2_WAY_BITS-1:0] l2_way_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRAIN = 3'd1,
    WALK  = 3'd2,
    FINAL = 3'd3,
    DONE  = 3'd4
  } flush_seq_state_t;

endpackage
`default_nettype wire

// File: rtl/l2_flush_walk_cnt.sv
`default_nettype none
// ============================================================================
// Module  : l2_flush_walk_cnt
// Purpose : Set/way counter pair for the flush walk. Way is the inner index,
//           set the outer one. Both wrap by natural modulo arithmetic.
// Ports   : clk_i    clock
//           rst_ni   asynchronous active-low reset
//           clear_i  force both counters to 0
//           inc_i    advance one step (way first, carry into set)
//           set_o    current set index
//           way_o    current way index
//           last_o   current step is (SETS-1, WAYS-1)
// Rev     : 1.0  initial release
// ============================================================================
module l2_flush_walk_cnt #(
  parameter int SETS     = 256,
  parameter int WAYS     = 8,
  parameter int SET_BITS = 8,
  parameter int WAY_BITS = 3
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic                inc_i,
  output logic [SET_BITS-1:0] set_o,
  output logic [WAY_BITS-1:0] way_o,
  output logic                last_o
);

  logic [SET_BITS-1:0] set_q, set_d;
  logic [WAY_BITS-1:0] way_q, way_d;

  always_comb begin
    set_d = set_q;
    way_d = way_q;
    if (clear_i) begin
      set_d = '0;
      way_d = '0;
    end else if (inc_i) begin
      way_d = way_q + WAY_BITS'(1);
      // WAYS is a power of two, so an all-ones way is the wrap point.
      if (&way_q) begin
        set_d = set_q + SET_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      set_q <= '0;
      way_q <= '0;
    end else begin
      set_q <= set_d;
      way_q <= way_d;
    end
  end

  assign set_o  = set_q;
  assign way_o  = way_q;
  assign last_o = (set_q == SET_BITS'(SETS - 1)) && (way_q == WAY_BITS'(WAYS - 1));

endmodule
`default_nettype wire

// File: rtl/l2_flush_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : l2_flush_sequencer
// Purpose : Accepts one flush command, waits for the L2 pipeline to drain,
//           walks every (set, way) handing one step per handshake to the
//           pipeline, waits for idle again and pulses flush_done_o.
// Ports   : clk_i           clock
//           rst_ni          asynchronous active-low reset
//           flush_valid_i   flush command valid
//           flush_is_all_i  1 = data + instruction lines, 0 = instr/clean only
//           flush_ready_o   command accepted on valid && ready
//           idle_i          pipeline has no outstanding work
//           evict_stall_i   pipeline cannot take a step this cycle
//           step_valid_o    step request to pipeline
//           step_ready_i    pipeline accepts step
//           step_set_o      set index of current step
//           step_way_o      way index of current step
//           step_is_all_o   latched flush_is_all_i
//           step_last_o     current step is the final (set, way)
//           busy_o          sequencer not in IDLE
//           flush_done_o    one-cycle completion pulse
// Rev     : 1.0  initial release
// ============================================================================
module l2_flush_sequencer
  import l2_flush_sequencer_pkg::*;
#(
  parameter int SETS     = L2_SETS,
  parameter int WAYS     = L2_WAYS,
  parameter int SET_BITS = L2_SET_BITS,
  parameter int WAY_BITS = L2_WAY_BITS
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_valid_i,
  input  logic                flush_is_all_i,
  output logic                flush_ready_o,
  input  logic                idle_i,
  input  logic                evict_stall_i,
  output logic                step_valid_o,
  input  logic                step_ready_i,
  output logic [SET_BITS-1:0] step_set_o,
  output logic [WAY_BITS-1:0] step_way_o,
  output logic                step_is_all_o,
  output logic                step_last_o,
  output logic                busy_o,
  output logic                flush_done_o
);

  flush_seq_state_t state_q, state_d;
  logic             is_all_q, is_all_d;
  logic             cnt_clear;
  logic             cnt_inc;
  logic             cnt_last;
  logic             step_hs;

  l2_flush_walk_cnt #(
    .SETS     (SETS),
    .WAYS     (WAYS),
    .SET_BITS (SET_BITS),
    .WAY_BITS (WAY_BITS)
  ) u_walk_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (cnt_clear),
    .inc_i   (cnt_inc),
    .set_o   (step_set_o),
    .way_o   (step_way_o),
    .last_o  (cnt_last)
  );

  always_comb begin
    state_d       = state_q;
    is_all_d      = is_all_q;
    flush_ready_o = 1'b0;
    step_valid_o  = 1'b0;
    busy_o        = 1'b1;
    flush_done_o  = 1'b0;
    cnt_clear     = 1'b0;
    cnt_inc       = 1'b0;
    step_hs       = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy_o        = 1'b0;
        flush_ready_o = 1'b1;
        if (flush_valid_i) begin
          is_all_d  = flush_is_all_i;
          cnt_clear = 1'b1;
          state_d   = DRAIN;
        end
      end
      DRAIN: begin
        if (idle_i) begin
          state_d = WALK;
        end
      end
      WALK: begin
        // Stall gates the request combinationally so no handshake can
        // complete in a cycle the pipeline cannot absorb a step.
        step_valid_o = !evict_stall_i;
        step_hs      = !evict_stall_i && step_ready_i;
        cnt_inc      = step_hs;
        // The counters wrap to 0 on the final handshake by modulo arithmetic.
        if (step_hs && cnt_last) begin
          state_d = FINAL;
        end
      end
      FINAL: begin
        if (idle_i) begin
          state_d = DONE;
        end
      end
      DONE: begin
        flush_done_o = 1'b1;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      is_all_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_all_q <= is_all_d;
    end
  end

  assign step_is_all_o = is_all_q;
  // Only meaningful while walking; keeps the output quiet elsewhere.
  assign step_last_o   = (state_q == WALK) && cnt_last;

endmodule
`default_nettype wire

// File: tb/tb_l2_flush_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_l2_flush_sequencer
// Purpose : Directed self-checking bench. A 4x2 instance covers the walk
//           order, drain/final waits, backpressure, stalls, ignored commands
//           and async reset; a default 256x8 instance covers a full walk.
// Rev     : 1.0  initial release
// ============================================================================
module tb_l2_flush_sequencer;

  localparam int S = 4;
  localparam int W = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic flush_valid, flush_is_all, idle, evict_stall, step_ready;
  logic flush_valid_b;

  logic       s_fready, s_valid, s_isall, s_last, s_busy, s_done;
  logic [1:0] s_set;
  logic [0:0] s_way;

  logic       b_fready, b_valid, b_isall, b_last, b_busy, b_done;
  logic [7:0] b_set;
  logic [2:0] b_way;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  l2_flush_sequencer #(
    .SETS(S), .WAYS(W), .SET_BITS(2), .WAY_BITS(1)
  ) u_small (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .flush_valid_i  (flush_valid),
    .flush_is_all_i (flush_is_all),
    .flush_ready_o  (s_fready),
    .idle_i         (idle),
    .evict_stall_i  (evict_stall),
    .step_valid_o   (s_valid),
    .step_ready_i   (step_ready),
    .step_set_o     (s_set),
    .step_way_o     (s_way),
    .step_is_all_o  (s_isall),
    .step_last_o    (s_last),
    .busy_o         (s_busy),
    .flush_done_o   (s_done)
  );

  l2_flush_sequencer u_big (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .flush_valid_i  (flush_valid_b),
    .flush_is_all_i (flush_is_all),
    .flush_ready_o  (b_fready),
    .idle_i         (idle),
    .evict_stall_i  (evict_stall),
    .step_valid_o   (b_valid),
    .step_ready_i   (step_ready),
    .step_set_o     (b_set),
    .step_way_o     (b_way),
    .step_is_all_o  (b_isall),
    .step_last_o    (b_last),
    .busy_o         (b_busy),
    .flush_done_o   (b_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered at posedge+1 in IDLE; leaves at posedge+1 in the first WALK cycle.
  task automatic start_flush(input logic is_all, input int drain, input bit keep);
    flush_is_all = is_all;
    flush_valid  = 1'b1;
    #1;
    chk("accept_ready", 32'(s_fready), 1);
    chk("accept_busy", 32'(s_busy), 0);
    tick();
    if (!keep) flush_valid = 1'b0;
    if (drain > 0) idle = 1'b0;
    for (int i = 0; i < drain; i++) begin
      chk("drain_valid", 32'(s_valid), 0);
      chk("drain_busy", 32'(s_busy), 1);
      chk("drain_ready", 32'(s_fready), 0);
      tick();
    end
    idle = 1'b1;
    chk("drain_last_valid", 32'(s_valid), 0);
    tick();
  endtask

  // Walks up to stop_at handshakes; optional step_ready hold (3 cycles) at
  // step hold_at and evict_stall (4 cycles) at step evict_at.
  task automatic walk(input int stop_at, input int hold_at, input int evict_at, input logic exp_all);
    int n = 0;
    int cyc = 0;
    int hold_cnt = 0;
    int ev_cnt = 0;
    while (n < stop_at && cyc < 60) begin
      step_ready  = 1'b1;
      evict_stall = 1'b0;
      if (n == hold_at && hold_cnt < 3) begin
        step_ready = 1'b0;
        hold_cnt++;
      end else if (n == evict_at && ev_cnt < 4) begin
        evict_stall = 1'b1;
        ev_cnt++;
      end
      #1;
      chk("walk_set", 32'(s_set), n / W);
      chk("walk_way", 32'(s_way), n % W);
      chk("walk_valid", 32'(s_valid), evict_stall ? 0 : 1);
      chk("walk_fready", 32'(s_fready), 0);
      chk("walk_isall", 32'(exp_all), 32'(s_isall));
      if (s_valid && step_ready) begin
        chk("walk_last", 32'(s_last), (n == S * W - 1) ? 1 : 0);
        n++;
      end
      tick();
      cyc++;
    end
    step_ready  = 1'b1;
    evict_stall = 1'b0;
    chk("handshakes", n, stop_at);
  endtask

  // Entered at posedge+1 in FINAL; leaves at posedge+1 in IDLE.
  task automatic finish(input int idle_low);
    if (idle_low > 0) idle = 1'b0;
    for (int i = 0; i < idle_low; i++) begin
      chk("final_wait_done", 32'(s_done), 0);
      chk("final_wait_busy", 32'(s_busy), 1);
      tick();
    end
    idle = 1'b1;
    chk("final_done", 32'(s_done), 0);
    chk("final_valid", 32'(s_valid), 0);
    chk("final_busy", 32'(s_busy), 1);
    tick();
    chk("done_pulse", 32'(s_done), 1);
    chk("done_fready", 32'(s_fready), 0);
    tick();
    chk("post_done", 32'(s_done), 0);
    chk("post_busy", 32'(s_busy), 0);
    chk("post_fready", 32'(s_fready), 1);
    chk("post_set", 32'(s_set), 0);
    chk("post_way", 32'(s_way), 0);
  endtask

  initial begin
    int n;
    int bad;
    int last_n;
    int last_cnt;
    int cyc;

    rst_n = 1'b0;
    flush_valid = 1'b0;
    flush_valid_b = 1'b0;
    flush_is_all = 1'b0;
    idle = 1'b1;
    evict_stall = 1'b0;
    step_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_fready", 32'(s_fready), 1);
    chk("rst_busy", 32'(s_busy), 0);
    chk("rst_valid", 32'(s_valid), 0);
    chk("rst_set", 32'(s_set), 0);
    chk("rst_way", 32'(s_way), 0);
    chk("rst_isall", 32'(s_isall), 0);
    chk("rst_done", 32'(s_done), 0);
    chk("rst_last", 32'(s_last), 0);
    rst_n = 1'b1;
    tick();

    // Basic flush
    start_flush(1'b1, 0, 1'b0);
    walk(8, -1, -1, 1'b1);
    finish(0);

    // Drain wait then delayed final
    start_flush(1'b0, 10, 1'b0);
    walk(8, -1, -1, 1'b0);
    finish(5);

    // Backpressure at (2,1) and evict stall at (1,0)
    start_flush(1'b1, 0, 1'b0);
    walk(8, 5, 2, 1'b1);
    finish(0);

    // Command held through the walk; second flush accepted in first IDLE
    start_flush(1'b0, 0, 1'b1);
    flush_is_all = 1'b1;
    walk(8, -1, -1, 1'b0);
    finish(0);
    tick();
    flush_valid = 1'b0;
    chk("second_busy", 32'(s_busy), 1);
    chk("second_fready", 32'(s_fready), 0);
    chk("second_done", 32'(s_done), 0);
    tick();
    walk(8, -1, -1, 1'b1);
    finish(0);

    // Async reset mid-walk at (2,0)
    start_flush(1'b1, 0, 1'b0);
    walk(4, -1, -1, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(s_busy), 0);
    chk("arst_valid", 32'(s_valid), 0);
    chk("arst_set", 32'(s_set), 0);
    chk("arst_way", 32'(s_way), 0);
    chk("arst_fready", 32'(s_fready), 1);
    chk("arst_isall", 32'(s_isall), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("arst_no_done", 32'(s_done), 0);
    end
    rst_n = 1'b1;
    tick();
    chk("arst_after_done", 32'(s_done), 0);
    start_flush(1'b0, 0, 1'b0);
    walk(8, -1, -1, 1'b0);
    finish(0);

    // Full-size walk on the default 256x8 instance
    flush_valid_b = 1'b1;
    #1;
    chk("big_fready", 32'(b_fready), 1);
    tick();
    flush_valid_b = 1'b0;
    chk("big_busy", 32'(b_busy), 1);
    tick();
    n = 0;
    bad = 0;
    last_n = -1;
    last_cnt = 0;
    cyc = 0;
    while (n < 2048 && cyc < 2200) begin
      if (b_valid && step_ready) begin
        if (int'(b_set) != n / 8 || int'(b_way) != n % 8) bad++;
        if (b_last) begin
          last_n = n;
          last_cnt++;
        end
        n++;
      end
      tick();
      cyc++;
    end
    chk("big_handshakes", n, 2048);
    chk("big_order_errs", bad, 0);
    chk("big_last_idx", last_n, 2047);
    chk("big_last_cnt", last_cnt, 1);
    chk("big_final_valid", 32'(b_valid), 0);
    tick();
    chk("big_done", 32'(b_done), 1);
    tick();
    chk("big_idle_busy", 32'(b_busy), 0);
    chk("big_idle_set", 32'(b_set), 0);
    chk("big_idle_way", 32'(b_way), 0);
    chk("big_idle_done", 32'(b_done), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/l2_flush_sequencer.md
Name: l2_flush_sequencer

Overview:
Sequences an L2 flush. It accepts one flush command, waits for in-flight requests to drain, then walks every (set, way) of the L2 in order and hands one step per handshake to the L2 pipeline. When the walk ends and the pipeline is idle again, it pulses flush_done. It sits between the flush input interface and the L2 input decoder/lookup path, and replaces ad-hoc flush_set/flush_way counters.

Parameters:
SETS, 256, number of L2 sets (power of 2)
WAYS, 8, number of L2 ways (power of 2)
SET_BITS, 8, log2(SETS)
WAY_BITS, 3, log2(WAYS)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
flush_valid  in  1  flush command valid
flush_is_all  in  1  1 = flush data and instruction lines; 0 = instruction/clean lines only
flush_ready  out  1  command accepted when flush_valid && flush_ready
idle  in  1  pipeline has no outstanding reqs entries and no set conflict
evict_stall  in  1  pipeline cannot take a step this cycle (reqs buffer full or eviction pending)
step_valid  out  1  step request to pipeline
step_ready  in  1  pipeline accepts step
step_set  out  SET_BITS  set index of current step
step_way  out  WAY_BITS  way index of current step
step_is_all  out  1  latched flush_is_all
step_last  out  1  current step is (SETS-1, WAYS-1)
busy  out  1  sequencer not in IDLE
flush_done  out  1  one-cycle completion pulse

Behaviour:
- Reset (rst=0, async): state=IDLE, set/way counters=0, is_all latch=0. All outputs 0 except flush_ready=1.
- States: IDLE, DRAIN, WALK, FINAL, DONE. All transitions happen on the clk rising edge.
- IDLE: flush_ready=1. On flush_valid, latch flush_is_all, clear counters, go to DRAIN. No step_valid.
- DRAIN: flush_ready=0. Go to WALK in the cycle after idle=1 is sampled; stay while idle=0.
- WALK: step_valid = !evict_stall. step_set/step_way show the counters; step_last = (set==SETS-1 && way==WAYS-1).
  - step_set/step_way/step_is_all hold steady while step_valid && !step_ready.
  - On handshake (step_valid && step_ready):
    - Way increments.
    - When way==WAYS-1, way wraps to 0 and set increments.
    - Handshake with step_last=1 goes to FINAL; counters wrap to 0.
  - evict_stall=1 forces step_valid=0 in the same cycle (combinational gate). Counters hold. No handshake counts while evict_stall=1.
- FINAL: step_valid=0. Go to DONE on the cycle after idle=1 is sampled.
- DONE: flush_done=1 for exactly one cycle, then IDLE. flush_ready is 0 in DONE, so a new flush_valid is accepted no earlier than the following IDLE cycle.
- busy=1 in every state except IDLE.
- Counter widths: set is SET_BITS wide and way is WAY_BITS wide. Wrap is natural modulo (no explicit compare needed for the wrap itself). step_last is detected by an explicit compare.
- Step count: exactly SETS*WAYS handshakes per flush, in order way-inner/set-outer. No step is repeated or skipped.
- flush_valid outside IDLE is ignored; it is not queued.
- Reset asserted mid-walk: immediate return to IDLE with counters=0. No flush_done is produced. A partially walked cache is the requester's concern.
- Simultaneous events:
  - evict_stall=1 and step_ready=1 in the same cycle: no handshake.
  - idle toggling during WALK has no effect.

Decomposition:
- Shared package (cache_consts/cache_types): L2_SETS, L2_WAYS, L2_SET_BITS, L2_WAY_BITS; l2_set_t, l2_way_t.
- Package also gets a new flush_seq_state_t enum {IDLE, DRAIN, WALK, FINAL, DONE} so the FSM and debug/stats logic share the encoding.
- Sub-module: l2_flush_walk_cnt, the set/way counter pair with increment, wrap and last detection.
- The FSM stays in the top module.

Test Plan:
- Basic flush, SETS=4 WAYS=2 override, idle=1, step_ready=1, evict_stall=0; pulse flush_valid with flush_is_all=1 -> DRAIN 1 cycle, then 8 consecutive handshakes (0,0)(0,1)(1,0)...(3,1), step_last only on (3,1), step_is_all=1 throughout, flush_done pulse 2 cycles after the last handshake, busy low after.
- Drain wait, idle=0 for 10 cycles after the command -> step_valid stays 0; first step (0,0) appears the cycle after idle rises. idle=0 for 5 cycles after step_last -> flush_done is delayed accordingly.
- Backpressure: step_ready low for 3 cycles at (2,1) -> step_set=2 and step_way=1 held stable. evict_stall=1 for 4 cycles at (1,0) -> step_valid=0 and counters frozen. Total handshakes remain 8.
- Ignored command, flush_valid high throughout the walk -> flush_ready=0, only one flush_done. A second flush is accepted on the first IDLE cycle after DONE.
- Async reset at step (2,0) while clk runs -> all outputs reset immediately, no flush_done. A new flush restarts from (0,0).
- Full size, default 256x8 -> exactly 2048 handshakes, final step (255,7) with step_last=1, then counters read 0 in IDLE.
